// File: rtl/care_action_ctrl.sv
// Button front end for the pet core: sync + debounce two raw buttons, track the selected
// care action, emit rate-limited one-hot action strobes. Optional macro: CARE_ACTION_REPEAT_EN.
module care_action_ctrl #(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int COOLDOWN_CYCLES = 13500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       btn_ok,
  output logic [2:0] sel,
  output logic [7:0] actions,
  output logic       busy
);
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int CW = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FIRE, COOL} state_t;

  // bit 0 = next, bit 1 = ok
  logic [1:0] w_raw;
  logic [1:0] r_s1, r_s2, r_deb, r_deb_d, r_armed, r_ev;
  logic [DW-1:0] r_dcnt [2];
  logic w_next_ev, w_ok_ev, w_repeat;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cool;
  logic [2:0]    r_sel, r_sel_lat, w_fire_sel;
  logic [7:0]    r_actions;
  logic          r_busy, w_fire;

  assign w_raw = {btn_ok, btn_next};

  // Synchronizers are deliberately not reset so they keep tracking a button held through reset.
  always_ff @(posedge clk) begin
    r_s1 <= w_raw;
    r_s2 <= r_s1;
  end

  // A button is armed only once its synchronized level has been seen low after reset,
  // so a press held across reset release never yields an event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_deb   <= '0;
      r_deb_d <= '0;
      r_armed <= '0;
      r_ev    <= '0;
      for (int i = 0; i < 2; i++) r_dcnt[i] <= '0;
    end else begin
      r_deb_d <= r_deb;
      r_armed <= r_armed | ~r_s2;
      r_ev    <= r_deb & ~r_deb_d & r_armed;
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] == r_deb[i]) begin
          r_dcnt[i] <= '0;
        end else if (r_dcnt[i] == DB_LAST) begin
          r_deb[i]  <= r_s2[i];
          r_dcnt[i] <= '0;
        end else begin
          r_dcnt[i] <= r_dcnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_next_ev = r_ev[0];
  assign w_ok_ev   = r_ev[1];

`ifdef CARE_ACTION_REPEAT_EN
  assign w_repeat = r_deb[1];
`else
  assign w_repeat = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_fire      = 1'b0;
    w_fire_sel  = r_sel_lat;
    case (r_state)
      IDLE: if (w_ok_ev) begin
        w_state_nxt = FIRE;
        w_fire      = 1'b1;
        w_fire_sel  = r_sel;
      end
      FIRE: w_state_nxt = COOL;
      COOL: if (r_cool == '0) begin
        if (w_repeat) begin
          w_state_nxt = FIRE;
          w_fire      = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Strobe and busy are registered off the next state so they line up with FIRE exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cool    <= '0;
      r_sel     <= '0;
      r_sel_lat <= '0;
      r_actions <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fire) r_sel_lat <= w_fire_sel;
      if (r_state == FIRE) r_cool <= CD_LOAD;
      else if (r_state == COOL && r_cool != '0) r_cool <= r_cool - 1'b1;
      r_actions <= w_fire ? (8'h01 << w_fire_sel) : 8'h00;
      r_busy    <= (w_state_nxt != IDLE);
      if (w_next_ev) r_sel <= (r_sel == 3'd5) ? 3'd0 : r_sel + 3'd1;
    end
  end

  assign sel     = r_sel;
  assign actions = r_actions;
  assign busy    = r_busy;
endmodule

// File: tb/tb_care_action_ctrl.sv
// Bench for care_action_ctrl: event-level model compared every cycle plus directed
// literal expectations for latency, selection stepping, glitches, drop, reset and repeat.
module tb_care_action_ctrl;
  localparam int D = 4;
  localparam int C = 8;
  localparam logic [63:0] MASK = (64'd1 << D) - 64'd1;
`ifdef CARE_ACTION_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_next = 1'b0;
  logic btn_ok = 1'b0;
  logic [2:0] sel;
  logic [7:0] actions;
  logic busy;

  care_action_ctrl #(.DEBOUNCE_CYCLES(D), .COOLDOWN_CYCLES(C)) dut (
    .clk(clk), .reset(reset), .btn_next(btn_next), .btn_ok(btn_ok),
    .sel(sel), .actions(actions), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  // ---------------- model ----------------
  logic [1:0]  m_s1 = '0, m_s2 = '0;
  logic [1:0]  m_deb = '0, m_rose = '0, m_armed = '0, m_ev = '0;
  logic [63:0] m_win [2] = '{64'd0, 64'd0};
  int          m_nv [2] = '{0, 0};
  int          m_rem = 0, m_sel = 0, m_lat = 0;
  logic [7:0]  m_act = '0;

  task automatic model_reset();
    m_deb = '0; m_rose = '0; m_armed = '0; m_ev = '0;
    m_win[0] = '0; m_win[1] = '0; m_nv[0] = 0; m_nv[1] = 0;
    m_rem = 0; m_sel = 0; m_lat = 0; m_act = '0;
  endtask

  // One clock edge: a level is accepted once the last D synchronized samples all disagree with it.
  task automatic model_step();
    logic [1:0] ev_new;
    logic ok_deb_pre;
    ok_deb_pre = m_deb[1];
    for (int b = 0; b < 2; b++) begin
      ev_new[b] = m_rose[b] & m_armed[b];
      m_armed[b] = m_armed[b] | ~m_s2[b];
      m_win[b] = {m_win[b][62:0], m_s2[b]};
      m_nv[b]++;
      m_rose[b] = 1'b0;
      if (m_nv[b] >= D && (m_win[b] & MASK) == (m_deb[b] ? 64'd0 : MASK)) begin
        m_deb[b] = ~m_deb[b];
        m_rose[b] = m_deb[b];
        m_nv[b] = 0;
      end
    end
    m_act = 8'h00;
    if (m_rem == 0) begin
      if (m_ev[1]) begin
        m_lat = m_sel;
        m_act = 8'(8'h01 << m_sel);
        m_rem = C + 1;
      end
    end else if (m_rem == 1 && REP && ok_deb_pre) begin
      m_act = 8'(8'h01 << m_lat);
      m_rem = C + 1;
    end else begin
      m_rem--;
    end
    if (m_ev[0]) m_sel = (m_sel + 1) % 6;
    m_ev = ev_new;
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) model_reset();
    else if (clk) model_step();
    if (clk) begin
      m_s2 = m_s1;
      m_s1 = {btn_ok, btn_next};
    end
  end

  // ---------------- strobe monitor ----------------
  int cyc = 0;
  int sq[$];
  logic [7:0] sv[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (actions != 8'h00) begin
    sq.push_back(cyc);
    sv.push_back(actions);
  end

  // ---------------- checking ----------------
  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("m_sel", 32'(sel), 32'(m_sel));
    chk("m_actions", 32'(actions), 32'(m_act));
    chk("m_busy", 32'(busy), 32'(m_rem > 0));
    #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  task automatic press(input bit ok, input int hold, input int gap);
    if (ok) btn_ok = 1'b1; else btn_next = 1'b1;
    wait_n(hold);
    if (ok) btn_ok = 1'b0; else btn_next = 1'b0;
    wait_n(gap);
  endtask

  int base, first, busyc;
  logic [7:0] first_act;
  int exp_sel [7] = '{1, 2, 3, 4, 5, 0, 1};

  initial begin
    wait_n(3);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_actions", 32'(actions), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    wait_n(5);

    // Latency and busy width from a held OK press
    base = sq.size(); first = 0; busyc = 0; first_act = '0;
    btn_ok = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (actions != 8'h00 && first == 0) begin first = k; first_act = actions; end
      if (busy) busyc++;
    end
    chk("t1_first_strobe_edge", 32'(first), 8);
    chk("t1_strobe_val", 32'(first_act), 32'h01);
    chk("t1_busy_cycles", 32'(busyc), 9);
`ifndef CARE_ACTION_REPEAT_EN
    wait_n(30);
    chk("t1_single_strobe", 32'(sq.size() - base), 1);
`endif
    btn_ok = 1'b0;
    wait_n(30);

    // Selection stepping with wrap, then an action on the new selection
    for (int i = 0; i < 7; i++) begin
      press(1'b0, 8, 12);
      chk("t2_sel", 32'(sel), 32'(exp_sel[i]));
    end
    base = sq.size();
    press(1'b1, 6, 30);
    chk("t2_strobe_cnt", 32'(sq.size() - base), 1);
    chk("t2_strobe_val", 32'(sv[sv.size()-1]), 32'h02);

    // Short glitches are ignored
    base = sq.size();
    press(1'b1, 3, 20);
    press(1'b0, 3, 20);
    chk("t3_no_strobe", 32'(sq.size() - base), 0);
    chk("t3_sel_kept", 32'(sel), 1);

    // Second OK lands during COOL and is dropped; NEXT changes sel during COOL
    base = sq.size();
    fork
      begin
        btn_ok = 1'b1; wait_n(4);
        btn_ok = 1'b0; wait_n(4);
        btn_ok = 1'b1; wait_n(10);
        btn_ok = 1'b0; wait_n(30);
      end
      begin
        repeat (2) @(negedge clk);
        #1 btn_next = 1'b1;
        repeat (6) @(negedge clk);
        #1 btn_next = 1'b0;
      end
    join
    chk("t4_strobe_cnt", 32'(sq.size() - base), REP ? 2 : 1);
    for (int i = base; i < sq.size(); i++) chk("t4_strobe_val", 32'(sv[i]), 32'h02);
    chk("t4_sel", 32'(sel), 2);

    // Reset two cycles into COOL, OK held across release
    base = sq.size();
    btn_ok = 1'b1;
    wait_n(11);
    reset = 1'b1;
    #1;
    chk("t5_rst_sel", 32'(sel), 0);
    chk("t5_rst_actions", 32'(actions), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    wait_n(3);
    reset = 1'b0;
    wait_n(40);
    chk("t5_held_no_strobe", 32'(sq.size() - base), 1);
    btn_ok = 1'b0;
    wait_n(10);
    press(1'b1, 6, 30);
    chk("t5_fresh_strobe_cnt", 32'(sq.size() - base), 2);
    chk("t5_fresh_strobe_val", 32'(sv[sv.size()-1]), 32'h01);

`ifdef CARE_ACTION_REPEAT_EN
    // Held OK repeats the latched action every 1+C cycles
    for (int i = 0; i < 4; i++) press(1'b0, 8, 12);
    chk("t6_sel", 32'(sel), 4);
    base = sq.size();
    btn_ok = 1'b1;
    wait_n(40);
    btn_ok = 1'b0;
    wait_n(30);
    chk("t6_strobe_cnt", 32'(sq.size() - base), 5);
    for (int i = base; i < sq.size(); i++) begin
      chk("t6_strobe_val", 32'(sv[i]), 32'h10);
      if (i > base) chk("t6_spacing", 32'(sq[i] - sq[i-1]), 9);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
